// File: rtl/seq_detector_param_if.sv
// Serial-stream, configuration and result signals of the pattern detector.
// The master drives the stream and configuration; the slave is the detector.
interface seq_detector_param_if #(
  parameter int MAX_W = 8,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(MAX_W + 1);

  logic             in_valid;
  logic             in;
  logic             cfg_load;
  logic [LW-1:0]    cfg_len;
  logic [MAX_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in, cfg_load, cfg_len, cfg_pattern, cfg_overlap, count_clr,
    input  out, match_count
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_len, cfg_pattern, cfg_overlap, count_clr,
    output out, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with a saturating match counter.
//   state | meaning
//   FILL  | fewer than len bits accepted since the last clear
//   ARMED | len bits held; every accepted bit is a match candidate
module seq_detector_param #(
  parameter int               MAX_W           = 8,
  parameter int               CNT_W           = 16,
  parameter int               DEFAULT_LEN     = 2,
  parameter logic [MAX_W-1:0] DEFAULT_PATTERN = MAX_W'(3),
  parameter bit               DEFAULT_OVERLAP = 1'b1
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);
  localparam int LW = $clog2(MAX_W + 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    len_q, len_load;
  logic [MAX_W-1:0] pattern_q;
  logic             overlap_q;
  logic [MAX_W-1:0] hist_q, hist_d, hist_shift, len_mask;
  logic [LW-1:0]    fill_q, fill_d, fill_inc;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, match;

  always_comb begin
    accept     = bus.in_valid & ~bus.cfg_load;
    hist_shift = {hist_q[MAX_W-2:0], bus.in};
    fill_inc   = (fill_q < len_q) ? fill_q + 1'b1 : fill_q;
    len_mask   = ~({MAX_W{1'b1}} << len_q);
    match      = accept && (((hist_shift ^ pattern_q) & len_mask) == '0)
                 && (fill_inc == len_q);
  end

  always_comb begin
    len_load = bus.cfg_len;
    if (bus.cfg_len == '0)
      len_load = LW'(1);
    else if (bus.cfg_len > LW'(MAX_W))
      len_load = LW'(MAX_W);
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    out_d   = 1'b0;
    if (bus.cfg_load) begin
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      out_d  = match;
      // Non-overlapping mode restarts the window after every hit.
      if (match && !overlap_q) begin
        state_d = FILL;
        fill_d  = '0;
      end else if (fill_inc == len_q) begin
        state_d = ARMED;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.count_clr)
      cnt_d = match ? CNT_W'(1) : '0;
    else if (match && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      len_q     <= LW'(DEFAULT_LEN);
      pattern_q <= DEFAULT_PATTERN;
      overlap_q <= DEFAULT_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      if (bus.cfg_load) begin
        len_q     <= len_load;
        pattern_q <= bus.cfg_pattern;
        overlap_q <= bus.cfg_overlap;
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable serial pattern detector. It is the next generation of the fixed two-consecutive-ones Moore detector. It accepts a qualified bit stream, compares the most recent 1..MAX_W accepted bits against a programmable pattern, and emits a one-cycle match pulse. It also keeps a saturating match counter and supports overlapping or non-overlapping detection. It sits on any serial control or data line in the design that needs framing or marker detection.

## Interface
- MAX_W, 8: maximum pattern length in bits (>= 2).
- CNT_W, 16: match counter width.
- DEFAULT_LEN, 2: pattern length after reset.
- DEFAULT_PATTERN, 8'b0000_0011: pattern after reset, MAX_W bits wide; the default reproduces "two consecutive 1s".
- DEFAULT_OVERLAP, 1: overlap mode after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies `in`; a bit is accepted on an edge where in_valid=1 and cfg_load=0.
- in  in  1  serial data bit.
- cfg_load  in  1  loads cfg_len, cfg_pattern and cfg_overlap, then clears detection history.
- cfg_len  in  $clog2(MAX_W+1)  pattern length.
- cfg_pattern  in  MAX_W  pattern; bit [len-1] is the first-received bit and bit [0] is the last.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- count_clr  in  1  synchronous clear of match_count.
- out  out  1  registered match pulse.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- History: a MAX_W-bit shift register. Each accepted bit shifts in at the LSB, so history[0] is always the newest bit.
- Fill counter: counts accepted bits since the last clear, saturating at the current length `len`.
- FSM states:
  - FILL: fill < len.
  - ARMED: fill == len.
  - Transition: FILL -> ARMED when the accepted bit makes fill reach len.
- Match condition on an accepting edge: the post-shift history[len-1:0] equals pattern[len-1:0] and the post-update fill == len.
- On a match:
  - out <= 1.
  - match_count increments unless it is all-ones (saturating).
  - Overlap=1: stay in ARMED; history is kept.
  - Overlap=0: return to FILL with fill=0; history bits are don't-care.
- Edges without a match: out <= 0. This includes edges where in_valid=0; such gaps never clear history or fill.
- cfg_load:
  - Takes priority over in_valid in the same cycle; that input bit is discarded.
  - Loads the configuration, sets history=0, fill=0, out<=0 and state FILL.
  - match_count is unchanged.
- cfg_len clamping: 0 loads as 1; values greater than MAX_W load as MAX_W.
- count_clr: if a match occurs in the same cycle, match_count becomes 1. Otherwise it becomes 0.
- Reset values (asserted asynchronously):
  - out=0, match_count=0, history=0, fill=0, state FILL.
  - len=DEFAULT_LEN, pattern=DEFAULT_PATTERN, overlap=DEFAULT_OVERLAP.
- Deassertion of rst is synchronised externally. The first accepting edge after reset release is treated as a normal edge.

## Timing
- Latency: out is high in the cycle immediately after the edge that accepted the completing bit, and stays high for exactly one cycle per match.
- match_count updates on that same edge.
- Back-to-back matches in overlap mode with len=1 give out high on consecutive cycles.
- A new configuration is effective from the edge following cfg_load. At least len further accepted bits are needed before the next match.
- Reset mid-stream forces out and match_count to 0 within the same cycle, with no clock required.

## Test plan
1. Defaults (len 2, pattern 11, overlap). Valid stream 0,1,1,1,0 on consecutive cycles -> out pulses after bits 3 and 4; match_count=2.
2. cfg_load with len 2, pattern 11, overlap=0; stream 1,1,1,1,1 -> out pulses after bits 2 and 4 only; match_count=2.
3. Defaults; bit 1, then in_valid=0 for 3 cycles, then bit 1 -> a single out pulse one cycle after the second accepted bit; out=0 throughout the gap.
4. cfg_load with len 4, pattern 4'b1011, overlap=1; stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; match_count=2.
   - Repeat with cfg_load asserted together with in_valid=1 on bit 1 -> that bit is discarded and no match occurs at bit 4.
5. CNT_W=3; drive 9 matches -> match_count saturates at 7.
   - count_clr together with a match -> match_count=1.
   - count_clr alone -> match_count=0.
6. Mid-stream with fill=1 and a custom config, drive rst=0 between edges -> out=0 and match_count=0 immediately.
   - After release, stream 1,1 -> match under the default pattern (config reverted).
